// File: rtl/metro_mpi_pkg.sv
// Shared types and constants for the metro MPI send path.
package metro_mpi_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_e;

   localparam int unsigned RANK_W     = 32;
   localparam int unsigned DEF_DATA_W = 64;

endpackage

// File: rtl/metro_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module metro_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int unsigned cand;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = (32'(ptr) + k) % N;
         if (!any && req[cand]) begin
            any         = 1'b1;
            idx         = IDX_W'(cand);
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/metro_tx_arbiter.sv
// Credit-gated round-robin arbiter feeding one MPI send channel, one message in flight.
module metro_tx_arbiter
   import metro_mpi_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned CREDITS = 8,
   parameter int unsigned DATA_W  = DEF_DATA_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]      req_data,
   input  logic [NUM_REQ*RANK_W-1:0]      req_dest,
   output logic [NUM_REQ-1:0]             req_yumi,
   output logic                           snd_valid,
   output logic [DATA_W-1:0]              snd_data,
   output logic [RANK_W-1:0]              snd_dest,
   input  logic                           snd_yumi,
   input  logic                           credit_ret,
   output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
   output logic                           credit_err
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(CREDITS + 1);

   tx_state_e          state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   credit_q, credit_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [RANK_W-1:0]  dest_q, dest_d;

   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               grant_ok;

   metro_rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // rst_n gating keeps req_yumi quiet while reset is asserted.
   assign grant_ok = rst_n && (state_q == IDLE) && (credit_q != '0) && arb_any;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      data_d   = data_q;
      dest_d   = dest_q;
      credit_d = credit_q;
      err_d    = err_q;
      req_yumi = '0;

      unique case (state_q)
         IDLE: begin
            if (grant_ok) begin
               state_d  = SEND;
               req_yumi = arb_grant;
               data_d   = req_data[arb_idx*DATA_W +: DATA_W];
               dest_d   = req_dest[arb_idx*RANK_W +: RANK_W];
               rr_ptr_d = (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
            end
         end
         SEND: begin
            if (snd_yumi) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Grant never fires at zero credits, so the decrement cannot underflow.
      if (grant_ok && !credit_ret) begin
         credit_d = credit_q - CNT_W'(1);
      end else if (!grant_ok && credit_ret) begin
         if (credit_q == CNT_W'(CREDITS)) err_d = 1'b1;
         else                             credit_d = credit_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         credit_q <= CNT_W'(CREDITS);
         err_q    <= 1'b0;
         data_q   <= '0;
         dest_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         credit_q <= credit_d;
         err_q    <= err_d;
         data_q   <= data_d;
         dest_q   <= dest_d;
      end
   end

   assign snd_valid  = (state_q == SEND);
   assign snd_data   = data_q;
   assign snd_dest   = dest_q;
   assign credit_cnt = credit_q;
   assign credit_err = err_q;

endmodule

// File: doc/metro_tx_arbiter.md
METRO_TX_ARBITER -- requirements
Module: metro_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of local requesters sharing one MPI send channel.
REQ-002 Parameter CREDITS, default 8: remote receive-buffer depth, the maximum number of messages in flight.
REQ-003 Parameter DATA_W, default 64: message width, matching the 64-bit metro_send payload.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester message-valid.
REQ-007 req_data  input  NUM_REQ*DATA_W  per-requester payload; slice i belongs to requester i.
REQ-008 req_dest  input  NUM_REQ*32  per-requester destination rank.
REQ-009 req_yumi  output  NUM_REQ  one-hot consume pulse to the granted requester.
REQ-010 snd_valid  output  1  message presented to the sender.
REQ-011 snd_data  output  DATA_W  latched payload.
REQ-012 snd_dest  output  32  latched destination rank.
REQ-013 snd_yumi  input  1  sender consumed the presented message.
REQ-014 credit_ret  input  1  one-cycle pulse: remote receiver freed one buffer slot.
REQ-015 credit_cnt  output  $clog2(CREDITS+1)  credits currently available.
REQ-016 credit_err  output  1  sticky: a credit return arrived while credit_cnt was already CREDITS.

Function
REQ-017 Two-state FSM: IDLE and SEND.
REQ-018 IDLE -> SEND in a cycle where credit_cnt>0 and any req_valid is high; otherwise the FSM stays in IDLE.
REQ-019 On that transition, the round-robin winner is the first valid index at or after rr_ptr, with wrap-around.
REQ-020 In the grant cycle, req_yumi[winner]=1 combinationally; every other req_yumi bit is 0.
REQ-021 In the grant cycle, req_data and req_dest of the winner are registered into snd_data/snd_dest; snd_valid=1 from the next cycle (one-cycle grant-to-valid latency).
REQ-022 In the grant cycle, rr_ptr <= (winner+1) mod NUM_REQ.
REQ-023 In the grant cycle, one credit is consumed.
REQ-024 SEND: snd_valid held high; snd_data and snd_dest held stable until snd_yumi.
REQ-025 SEND -> IDLE in the cycle snd_yumi=1; snd_valid is 0 the following cycle.
REQ-026 No grant is made while in SEND: at most one message is outstanding toward the sender, and a new grant occurs no earlier than the cycle after snd_yumi.
REQ-027 snd_yumi while in IDLE is ignored.
REQ-028 credit_ret alone increments credit_cnt.
REQ-029 A grant and a credit_ret in the same cycle leave credit_cnt unchanged.
REQ-030 A credit_ret (without a same-cycle grant) while credit_cnt==CREDITS leaves the count at CREDITS and sets credit_err.
REQ-031 With credit_cnt==0, requests are held off (req_yumi=0) until a credit_ret arrives; a grant may occur in the cycle after the return.
REQ-032 req_valid dropping without a yumi is legal; an unselected requester is never yumi'd.

Reset
REQ-033 While rst_n==0 at a clock edge, the following are set: state=IDLE, rr_ptr=0, credit_cnt=CREDITS, snd_valid=0, snd_data=0, snd_dest=0, credit_err=0.
REQ-034 req_yumi=0 while rst_n==0.
REQ-035 A reset during SEND drops the in-flight message without yumi to the sender side; the requester was already yumi'd and is not re-granted.

Structure
REQ-036 Package metro_mpi_pkg holds the FSM state enum (IDLE, SEND), the rank width constant (32), and the default DATA_W.
REQ-037 The winner selection is a combinational sub-module metro_rr_arbiter with inputs req and ptr and outputs one-hot grant, index and any.
REQ-038 The counter, FSM and output registers reside in metro_tx_arbiter.
REQ-039 Total RTL is within 120-400 lines.

Verification
REQ-040 Reset, then req_valid=4'b0001 with data 0xA5, dest 0 -> req_yumi[0] pulses in cycle 1; snd_valid=1, snd_data=0xA5 in cycle 2; snd_yumi in cycle 4 -> snd_valid=0 in cycle 5; credit_cnt=7.
REQ-041 All four requesters valid continuously, snd_yumi one cycle after each snd_valid, with credit_ret pulsed one cycle after each snd_yumi -> grant order 0,1,2,3,0; credit_cnt never below 7.
REQ-042 CREDITS=8, no credit_ret, requester 2 continuously valid -> exactly 8 grants, then credit_cnt=0 and req_yumi stays 0; one credit_ret -> exactly one further grant.
REQ-043 Grant cycle coincident with credit_ret at credit_cnt=3 -> credit_cnt stays 3; credit_ret at credit_cnt=8 -> credit_cnt stays 8 and credit_err=1 and holds.
REQ-044 rst_n low for one cycle while in SEND with snd_data=0x55 -> next cycle: snd_valid=0, credit_cnt=8, rr_ptr=0, and the grant after reset goes to the lowest valid index.
